// File: rtl/video_stream_pkg.sv
// video_stream_pkg: shared pixel type, source FSM states and default image geometry
package video_stream_pkg;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;
  localparam int PIX_W = 12;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} src_state_t;
endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry buffer of tagged pixels, head entry drives the stream outputs
module stream_skid_fifo
  import video_stream_pkg::*;
#(
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_sop,
  input  logic              din_eop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_sop,
  output logic              head_eop,
  output logic [1:0]        count
);
  localparam int E = DATA_W + 2;
  logic [E-1:0] e0_q, e0_d, e1_q, e1_d, din;
  logic [1:0] count_q, count_d, rem;
  assign din = {din_data, din_sop, din_eop};
  // pop shifts entry 1 into the head, then a push lands in the first free slot
  always_comb begin
    rem = count_q - {1'b0, pop};
    e0_d = (push && rem == 2'd0) ? din : (pop ? e1_q : e0_q);
    e1_d = (push && rem == 2'd1) ? din : e1_q;
    count_d = rem + {1'b0, push};
  end
  // storage and occupancy registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
  end
  assign {head_data, head_sop, head_eop} = e0_q;
  assign count = count_q;
endmodule

// File: rtl/image_stream_source.sv
// image_stream_source: streams one raster-ordered frame from a sync ROM as a sop/eop packet
module image_stream_source
  import video_stream_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DATA_W = PIX_W,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              sop_out,
  output logic              eop_out,
  output logic              valid_out,
  output logic              busy,
  output logic              frame_done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
  src_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic in_flight_q, in_flight_d;
  logic [1:0] tag_q, tag_d;
  logic [1:0] count;
  logic [2:0] occ;
  logic pop;
  assign pop = valid_out && ready_in;
  stream_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk(clk), .reset(reset), .push(in_flight_q), .pop(pop),
    .din_data(mem_rd_data), .din_sop(tag_q[1]), .din_eop(tag_q[0]),
    .head_data(data_out), .head_sop(sop_out), .head_eop(eop_out), .count(count)
  );
  assign valid_out = count != 2'd0;
  assign busy = state_q != IDLE;
  assign mem_addr = addr_q;
  // next state, read issue gated on buffer room after this cycle's pop, frame completion
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    mem_rd_en = 1'b0;
    frame_done = 1'b0;
    occ = {1'b0, count} + {2'b0, in_flight_q} - {2'b0, pop};
    unique case (state_q)
      IDLE: state_d = (start || continuous) ? STREAM : IDLE;
      STREAM: begin
        mem_rd_en = occ < 3'd2;
        addr_d = !mem_rd_en ? addr_q : (addr_q == LAST ? '0 : addr_q + ADDR_W'(1));
        state_d = (mem_rd_en && addr_q == LAST) ? DRAIN : STREAM;
      end
      DRAIN: begin
        frame_done = count == 2'd0 && !in_flight_q;
        state_d = !frame_done ? DRAIN : (continuous ? STREAM : IDLE);
      end
      default: state_d = IDLE;
    endcase
    in_flight_d = mem_rd_en;
    tag_d = mem_rd_en ? {addr_q == '0, addr_q == LAST} : tag_q;
  end
  // FSM, address counter and in-flight read tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      in_flight_q <= 1'b0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      in_flight_q <= in_flight_d;
      tag_q <= tag_d;
    end
  end
endmodule
